// File: rtl/cpu_trace_buf.sv
// cpu_trace_buf: circular PC/probe trace capture for the MIPS core.
// Freezes on a trigger after a programmable post-trigger sample count.
module cpu_trace_buf #(
    parameter int PC_W   = 8,
    parameter int DATA_W = 16,
    parameter int DEPTH  = 16,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   r_st,
    input  logic                   arm,
    input  logic                   abort,
    input  logic                   trig_mode,
    input  logic                   trig,
    input  logic [PC_W-1:0]        trig_pc,
    input  logic [AW:0]            post_cnt,
    input  logic                   smp_valid,
    input  logic [PC_W-1:0]        smp_pc,
    input  logic [DATA_W-1:0]      smp_data,
    input  logic [AW-1:0]          rd_idx,
    output logic [PC_W+DATA_W-1:0] rd_data,
    output logic [AW:0]            fill,
    output logic [AW-1:0]          trig_pos,
    output logic                   busy,
    output logic                   triggered,
    output logic                   done
);

    localparam int SW = PC_W + DATA_W;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_PRE  = 2'd1;
    localparam logic [1:0] S_POST = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [AW:0]   FULL    = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] MAX_POST = AW'(DEPTH - 1);

    logic [SW-1:0] mem [DEPTH];

    logic [1:0]      state;
    logic [1:0]      state_nxt;
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   trig_addr;
    logic [AW-1:0]   remaining;
    logic            mode_q;
    logic [PC_W-1:0] tpc_q;
    logic [AW-1:0]   post_q;

    logic            capturing;
    logic            wr_en;
    logic            hit;
    logic            start;
    logic            last_post;
    logic            to_done;
    logic [AW-1:0]   post_clamp;
    logic [AW-1:0]   wr_ptr_nxt;
    logic [AW:0]     fill_nxt;
    logic [AW-1:0]   oldest;
    logic [AW-1:0]   oldest_nxt;
    logic [AW-1:0]   taddr_nxt;
    logic [AW-1:0]   rd_addr;
    logic            rd_hit;

    assign capturing = ((state == S_PRE) || (state == S_POST)) && !abort;
    assign wr_en     = capturing && smp_valid;
    assign hit       = wr_en && (state == S_PRE) &&
                       (mode_q ? (smp_pc == tpc_q) : trig);
    assign start     = ((state == S_IDLE) || (state == S_DONE)) &&
                       arm && !abort;
    assign last_post = wr_en && (state == S_POST) &&
                       (remaining == AW'(1));
    assign to_done   = (hit && (post_q == '0)) || last_post;

    assign post_clamp = (post_cnt >= FULL) ? MAX_POST : post_cnt[AW-1:0];

    // Next-write view, so trig_pos reflects the buffer after the final write
    assign wr_ptr_nxt = wr_ptr + AW'(1);
    assign fill_nxt   = (fill == FULL) ? fill : fill + (AW+1)'(1);
    assign oldest_nxt = (fill_nxt < FULL) ? '0 : wr_ptr_nxt;
    assign taddr_nxt  = hit ? wr_ptr : trig_addr;

    assign oldest  = (fill < FULL) ? '0 : wr_ptr;
    assign rd_addr = oldest + rd_idx;
    assign rd_hit  = {1'b0, rd_idx} < fill;

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE, S_DONE: begin
                if (start) state_nxt = S_PRE;
            end
            S_PRE: begin
                if (abort)
                    state_nxt = S_IDLE;
                else if (hit)
                    state_nxt = (post_q == '0) ? S_DONE : S_POST;
            end
            S_POST: begin
                if (abort)
                    state_nxt = S_IDLE;
                else if (last_post)
                    state_nxt = S_DONE;
            end
        endcase
    end

    // Storage is not reset; fill gating hides stale entries
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= {smp_pc, smp_data};
    end

    always_ff @(posedge clk or posedge r_st) begin
        if (r_st) begin
            state     <= S_IDLE;
            wr_ptr    <= '0;
            fill      <= '0;
            trig_addr <= '0;
            trig_pos  <= '0;
            remaining <= '0;
            mode_q    <= 1'b0;
            tpc_q     <= '0;
            post_q    <= '0;
            rd_data   <= '0;
            busy      <= 1'b0;
            triggered <= 1'b0;
            done      <= 1'b0;
        end else begin
            state <= state_nxt;
            busy  <= (state_nxt == S_PRE) || (state_nxt == S_POST);
            done  <= (state_nxt == S_DONE);

            rd_data <= rd_hit ? mem[rd_addr] : '0;

            if (start) begin
                wr_ptr    <= '0;
                fill      <= '0;
                triggered <= 1'b0;
                mode_q    <= trig_mode;
                tpc_q     <= trig_pc;
                post_q    <= post_clamp;
            end else if (wr_en) begin
                wr_ptr <= wr_ptr_nxt;
                fill   <= fill_nxt;
            end

            if (hit) begin
                triggered <= 1'b1;
                trig_addr <= wr_ptr;
                remaining <= post_q;
            end else if (wr_en && (state == S_POST)) begin
                remaining <= remaining - AW'(1);
            end

            if (to_done) trig_pos <= taddr_nxt - oldest_nxt;
        end
    end

endmodule

// File: tb/tb_cpu_trace_buf.sv
// Bench for cpu_trace_buf: directed scenarios plus random traffic
// against a queue-based history model.
module tb_cpu_trace_buf;

    logic        clk = 1'b0;
    logic        r_st;
    logic        arm;
    logic        abort;
    logic        trig_mode;
    logic        trig;
    logic [7:0]  trig_pc;
    logic [4:0]  post_cnt;
    logic        smp_valid;
    logic [7:0]  smp_pc;
    logic [15:0] smp_data;
    logic [3:0]  rd_idx;
    logic [23:0] rd_data;
    logic [4:0]  fill;
    logic [3:0]  trig_pos;
    logic        busy;
    logic        triggered;
    logic        done;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: 0 idle, 1 pre, 2 post, 3 done
    int          m_st;
    logic [23:0] hist[$];
    int          m_trig_n;
    bit          m_trig;
    int          m_post;
    int          m_rem;
    bit          m_mode;
    logic [7:0]  m_tpc;
    int          m_tp;
    logic [23:0] exp_rd;

    cpu_trace_buf dut (
        .clk       (clk),
        .r_st      (r_st),
        .arm       (arm),
        .abort     (abort),
        .trig_mode (trig_mode),
        .trig      (trig),
        .trig_pc   (trig_pc),
        .post_cnt  (post_cnt),
        .smp_valid (smp_valid),
        .smp_pc    (smp_pc),
        .smp_data  (smp_data),
        .rd_idx    (rd_idx),
        .rd_data   (rd_data),
        .fill      (fill),
        .trig_pos  (trig_pos),
        .busy      (busy),
        .triggered (triggered),
        .done      (done)
    );

    always #5 clk = ~clk;

    function automatic int m_fill();
        return (hist.size() < 16) ? hist.size() : 16;
    endfunction

    function automatic logic [23:0] m_read(int idx);
        int n = hist.size();
        int f = m_fill();
        if (idx < f) return hist[n - f + idx];
        return '0;
    endfunction

    task automatic model_reset();
        hist.delete();
        m_st   = 0;
        m_trig = 1'b0;
        m_tp   = 0;
        m_rem  = 0;
        exp_rd = '0;
    endtask

    task automatic enter_done();
        int n = hist.size();
        int f = m_fill();
        m_st = 3;
        m_tp = m_trig_n - (n - f);
    endtask

    task automatic idle_inputs();
        arm       = 1'b0;
        abort     = 1'b0;
        trig      = 1'b0;
        smp_valid = 1'b0;
        smp_pc    = '0;
        smp_data  = '0;
    endtask

    // One clock: expected read from pre-edge history, then model update
    task automatic tick();
        bit h;
        exp_rd = m_read(int'(rd_idx));
        @(posedge clk);
        if (m_st == 0 || m_st == 3) begin
            if (arm && !abort) begin
                hist.delete();
                m_trig = 1'b0;
                m_mode = trig_mode;
                m_tpc  = trig_pc;
                m_post = (post_cnt > 5'd15) ? 15 : int'(post_cnt);
                m_st   = 1;
            end
        end else if (abort) begin
            m_st = 0;
        end else if (smp_valid) begin
            hist.push_back({smp_pc, smp_data});
            if (m_st == 1) begin
                h = m_mode ? (smp_pc == m_tpc) : trig;
                if (h) begin
                    m_trig   = 1'b1;
                    m_trig_n = hist.size() - 1;
                    if (m_post == 0) enter_done();
                    else begin
                        m_rem = m_post;
                        m_st  = 2;
                    end
                end
            end else begin
                m_rem--;
                if (m_rem == 0) enter_done();
            end
        end
        #1;
    endtask

    task automatic do_arm(input bit mode, input logic [7:0] tpc,
                          input logic [4:0] pc_cnt);
        idle_inputs();
        arm       = 1'b1;
        trig_mode = mode;
        trig_pc   = tpc;
        post_cnt  = pc_cnt;
        tick();
        arm = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        trig_mode = 1'b0;
        trig_pc   = '0;
        post_cnt  = '0;
        rd_idx    = '0;
        r_st      = 1'b0;
        #1 r_st = 1'b1;
        #2;
        model_reset();
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0 || triggered !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_flags busy=%b done=%b trig=%b want 0",
                     busy, done, triggered);
        end
        n_checks++;
        if (fill !== 5'd0 || trig_pos !== 4'd0 || rd_data !== 24'd0) begin
            n_fail++;
            $display("FAIL reset_regs fill=%0d tp=%0d rd=%h want 0",
                     fill, trig_pos, rd_data);
        end
        @(posedge clk);
        #1 r_st = 1'b0;
    endtask

    task automatic test_reset_mid();
        do_arm(1'b0, 8'd0, 5'd3);
        for (int i = 0; i < 5; i++) begin
            smp_valid = 1'b1;
            smp_pc    = 8'(i);
            smp_data  = 16'($urandom);
            tick();
        end
        idle_inputs();
        n_checks++;
        if (fill !== 5'd5 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_pre fill=%0d busy=%b want 5/1", fill, busy);
        end
        #2 r_st = 1'b1;
        #1;
        model_reset();
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0 || fill !== 5'd0) begin
            n_fail++;
            $display("FAIL mid_reset busy=%b done=%b fill=%0d want 0",
                     busy, done, fill);
        end
        r_st   = 1'b0;
        rd_idx = 4'd0;
        @(posedge clk);
        #1;
        tick();
        n_checks++;
        if (rd_data !== 24'd0) begin
            n_fail++;
            $display("FAIL mid_read rd=%h want 0", rd_data);
        end
    endtask

    task automatic test_ext_trig();
        do_arm(1'b0, 8'd0, 5'd3);
        for (int pc = 0; pc < 30; pc++) begin
            smp_valid = 1'b1;
            smp_pc    = 8'(pc);
            smp_data  = 16'($urandom);
            trig      = (pc == 20);
            tick();
            if (pc == 22) begin
                n_checks++;
                if (done !== 1'b0) begin
                    n_fail++;
                    $display("FAIL ext_early done=%b want 0", done);
                end
            end
            if (pc == 23) begin
                n_checks++;
                if (done !== 1'b1 || busy !== 1'b0) begin
                    n_fail++;
                    $display("FAIL ext_done done=%b busy=%b want 1/0",
                             done, busy);
                end
            end
        end
        idle_inputs();
        n_checks++;
        if (fill !== 5'd16 || trig_pos !== 4'd12 || triggered !== 1'b1) begin
            n_fail++;
            $display("FAIL ext_stat fill=%0d tp=%0d trg=%b want 16/12/1",
                     fill, trig_pos, triggered);
        end
        rd_idx = 4'd0;
        tick();
        n_checks++;
        if (rd_data[23:16] !== 8'd8 || rd_data !== exp_rd) begin
            n_fail++;
            $display("FAIL ext_rd0 rd=%h want pc 08 (%h)", rd_data, exp_rd);
        end
        rd_idx = 4'd15;
        tick();
        n_checks++;
        if (rd_data[23:16] !== 8'd23 || rd_data !== exp_rd) begin
            n_fail++;
            $display("FAIL ext_rd15 rd=%h want pc 17 (%h)", rd_data, exp_rd);
        end
    endtask

    task automatic test_rearm();
        idle_inputs();
        arm       = 1'b1;
        smp_valid = 1'b1;
        smp_pc    = 8'haa;
        trig_mode = 1'b0;
        post_cnt  = 5'd2;
        tick();
        idle_inputs();
        n_checks++;
        if (fill !== 5'd0 || triggered !== 1'b0 || busy !== 1'b1 ||
            done !== 1'b0) begin
            n_fail++;
            $display("FAIL rearm fill=%0d trg=%b busy=%b done=%b want 0/0/1/0",
                     fill, triggered, busy, done);
        end
        rd_idx = 4'd0;
        tick();
        n_checks++;
        if (rd_data !== 24'd0 || fill !== 5'd0) begin
            n_fail++;
            $display("FAIL rearm_rd rd=%h fill=%0d want 0/0", rd_data, fill);
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
    endtask

    task automatic test_pc_match();
        do_arm(1'b1, 8'h05, 5'd0);
        for (int pc = 0; pc < 10; pc++) begin
            smp_valid = 1'b1;
            smp_pc    = 8'(pc);
            smp_data  = 16'($urandom);
            tick();
            smp_valid = 1'b0;
            smp_pc    = 8'hff;
            tick();
        end
        idle_inputs();
        n_checks++;
        if (fill !== 5'd6 || trig_pos !== 4'd5 || done !== 1'b1) begin
            n_fail++;
            $display("FAIL pcm_stat fill=%0d tp=%0d done=%b want 6/5/1",
                     fill, trig_pos, done);
        end
        rd_idx = 4'd6;
        tick();
        n_checks++;
        if (rd_data !== 24'd0) begin
            n_fail++;
            $display("FAIL pcm_rd6 rd=%h want 0", rd_data);
        end
        rd_idx = 4'd0;
        tick();
        n_checks++;
        if (rd_data[23:16] !== 8'd0 || rd_data !== exp_rd) begin
            n_fail++;
            $display("FAIL pcm_rd0 rd=%h want %h", rd_data, exp_rd);
        end
    endtask

    task automatic test_clamp();
        do_arm(1'b0, 8'd0, 5'd20);
        for (int pc = 0; pc <= 40; pc++) begin
            smp_valid = 1'b1;
            smp_pc    = 8'(pc);
            smp_data  = 16'($urandom);
            trig      = (pc == 0);
            tick();
        end
        idle_inputs();
        n_checks++;
        if (fill !== 5'd16 || trig_pos !== 4'd0 || done !== 1'b1) begin
            n_fail++;
            $display("FAIL clamp_stat fill=%0d tp=%0d done=%b want 16/0/1",
                     fill, trig_pos, done);
        end
        rd_idx = 4'd15;
        tick();
        n_checks++;
        if (rd_data[23:16] !== 8'd15 || rd_data !== exp_rd) begin
            n_fail++;
            $display("FAIL clamp_rd15 rd=%h want pc 0f (%h)", rd_data, exp_rd);
        end
    endtask

    task automatic test_abort();
        do_arm(1'b0, 8'd0, 5'd5);
        for (int pc = 0; pc < 4; pc++) begin
            smp_valid = 1'b1;
            smp_pc    = 8'(pc);
            smp_data  = 16'($urandom);
            trig      = (pc == 1);
            tick();
        end
        idle_inputs();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0 || fill !== 5'd4) begin
            n_fail++;
            $display("FAIL abort busy=%b done=%b fill=%0d want 0/0/4",
                     busy, done, fill);
        end
        rd_idx = 4'd3;
        tick();
        n_checks++;
        if (rd_data[23:16] !== 8'd3 || rd_data !== exp_rd) begin
            n_fail++;
            $display("FAIL abort_rd rd=%h want pc 03 (%h)", rd_data, exp_rd);
        end
        arm   = 1'b1;
        abort = 1'b1;
        tick();
        idle_inputs();
        n_checks++;
        if (busy !== 1'b0 || fill !== 5'd4) begin
            n_fail++;
            $display("FAIL arm_abort busy=%b fill=%0d want 0/4", busy, fill);
        end
        do_arm(1'b0, 8'd0, 5'd5);
        arm       = 1'b1;
        smp_valid = 1'b1;
        smp_pc    = 8'h33;
        tick();
        idle_inputs();
        n_checks++;
        if (busy !== 1'b1 || fill !== 5'd1) begin
            n_fail++;
            $display("FAIL arm_in_pre busy=%b fill=%0d want 1/1", busy, fill);
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
    endtask

    task automatic test_random();
        for (int c = 0; c < 3000; c++) begin
            idle_inputs();
            arm   = ($urandom_range(0, 15) == 0);
            abort = ($urandom_range(0, 63) == 0);
            if (arm) begin
                trig_mode = 1'($urandom);
                trig_pc   = 8'($urandom_range(0, 15));
                post_cnt  = 5'($urandom_range(0, 31));
            end
            smp_valid = !abort && ($urandom_range(0, 1) == 1);
            smp_pc    = 8'($urandom_range(0, 15));
            smp_data  = 16'($urandom);
            trig      = ($urandom_range(0, 9) == 0);
            rd_idx    = 4'($urandom);
            tick();
            n_checks++;
            if (busy !== (m_st == 1 || m_st == 2) || done !== (m_st == 3)) begin
                n_fail++;
                $display("FAIL rnd_state c=%0d busy=%b done=%b model_st=%0d",
                         c, busy, done, m_st);
            end
            n_checks++;
            if (triggered !== m_trig) begin
                n_fail++;
                $display("FAIL rnd_trig c=%0d got %b want %b", c, triggered, m_trig);
            end
            n_checks++;
            if (fill !== 5'(m_fill())) begin
                n_fail++;
                $display("FAIL rnd_fill c=%0d got %0d want %0d", c, fill, m_fill());
            end
            n_checks++;
            if (trig_pos !== 4'(m_tp)) begin
                n_fail++;
                $display("FAIL rnd_tpos c=%0d got %0d want %0d", c, trig_pos, m_tp);
            end
            n_checks++;
            if (rd_data !== exp_rd) begin
                n_fail++;
                $display("FAIL rnd_rd c=%0d got %h want %h", c, rd_data, exp_rd);
            end
        end
    endtask

    initial begin
        test_reset();
        test_reset_mid();
        test_ext_trig();
        test_rearm();
        test_pc_match();
        test_clamp();
        test_abort();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cpu_trace_buf.md
# cpu_trace_buf

Parametrised, synthesizable pipeline trace-capture block for the 16-bit 5-stage MIPS core. It records per-cycle (PC, probe-data) samples into a circular buffer, freezes on a trigger (external strobe or PC match), and keeps a programmable number of post-trigger samples. Readout is by oldest-relative index, so a bench or the `select_y` display path can inspect pipeline history without `$monitor`. It sits beside `cpu_top` and taps `core.pc` plus one selectable probe word.

## Interface
- `PC_W`, 8: sample PC width.
- `DATA_W`, 16: probe data width.
- `DEPTH`, 16: buffer entries; power of two, ≥4.
- `AW`, $clog2(DEPTH): index width (derived).

Ports:
- `clk` in 1: single clock, rising edge.
- `r_st` in 1: reset, asynchronous, active-high.
- `arm` in 1: start a capture (pulse).
- `abort` in 1: stop the capture, go to IDLE.
- `trig_mode` in 1: 0 = external `trig`; 1 = PC match. Latched at arm.
- `trig` in 1: external trigger, qualified by `smp_valid`.
- `trig_pc` in PC_W: match value, latched at arm.
- `post_cnt` in AW+1: samples kept after the trigger sample, latched at arm, clamped to DEPTH-1.
- `smp_valid` in 1: sample strobe.
- `smp_pc` in PC_W, `smp_data` in DATA_W: sample payload.
- `rd_idx` in AW: read index, 0 = oldest.
- `rd_data` out PC_W+DATA_W: registered read data, {pc, data}.
- `fill` out AW+1: valid entries, 0..DEPTH.
- `trig_pos` out AW: oldest-relative index of the trigger sample.
- `busy`, `triggered`, `done` out 1: status flags.

## Operation
- States:
  - IDLE: reset state.
  - PRE: armed, writing, waiting for the trigger.
  - POST: writing the remaining samples.
  - DONE: frozen.
- `arm` in IDLE or DONE: on the next edge, clear wr_ptr, fill and triggered, latch the config, and enter PRE. A sample presented in the arm cycle is not captured. `arm` in PRE/POST is ignored.
- `abort` in PRE/POST: go to IDLE. Memory, fill and wr_ptr are kept and remain readable. `abort` wins over a simultaneous `arm`.
- In PRE/POST, each `smp_valid` cycle:
  - Write {smp_pc, smp_data} to mem[wr_ptr].
  - wr_ptr increments mod DEPTH.
  - fill increments, saturating at DEPTH.
- Trigger, evaluated in PRE only:
  - Condition: `smp_valid & (trig_mode ? smp_pc==trig_pc : trig)`.
  - The trigger sample itself is written.
  - Record its address as trig_addr.
  - If the latched post count is 0, go to DONE; else load remaining = post count and go to POST.
- POST: each valid sample decrements remaining. The write that takes remaining to 0 moves the block to DONE. Cycles without `smp_valid` do not count.
- DONE: no writes, everything holds until `arm` or reset.
- Readout:
  - oldest = (fill<DEPTH) ? 0 : wr_ptr.
  - rd_data <= (rd_idx < fill) ? mem[(oldest+rd_idx) mod DEPTH] : 0.
  - Valid in every state.
- `trig_pos` = (trig_addr − oldest) mod DEPTH. Updated when DONE is entered; 0 until the first trigger.
- Arithmetic: all pointer math is mod DEPTH (AW bits); fill is AW+1 bits.

## Timing
- Reset (async): state=IDLE, wr_ptr=0, fill=0, trig_pos=0, rd_data=0, busy=0, triggered=0, done=0. Memory is not reset; the fill gating hides stale contents.
- busy=1 exactly in PRE/POST; done=1 exactly in DONE. Both are registered and change on the edge that changes state.
- triggered goes high on the edge that writes the trigger sample and stays high until re-arm or reset.
- rd_data latency: 1 cycle from `rd_idx`. A write and a read of the same entry in the same cycle returns the old content.
- Capture of N samples completes on the edge of the last valid sample; done is visible in the following cycle.
- `r_st` mid-capture: immediate IDLE, fill=0.

## Test plan
- Reset mid-capture: arm, feed 5 samples, pulse `r_st` between edges → busy=0, done=0, fill=0 at once; rd_data=0 on the next read.
- External trigger (DEPTH=16, post_cnt=3): arm, then pc 0..29 valid every cycle, `trig` with pc=20 → done after pc=23 is written, no further writes. Expect fill=16, trig_pos=12, rd_idx 0→pc 8, rd_idx 15→pc 23.
- PC match (trig_mode=1, trig_pc=0x05, post_cnt=0): samples pc 0..9 with `smp_valid` low every other cycle → done after pc 5. Expect fill=6, trig_pos=5, rd_idx 6→0, rd_idx 0→pc 0.
- Clamp: post_cnt=20, trigger on the first sample pc 0, pcs 0..40 → captures pc 0..15. Expect fill=16, trig_pos=0, rd_idx 15→pc 15.
- Abort/arm priority: abort in POST → IDLE with fill retained and readable. Assert `arm` and `abort` in the same cycle → stays IDLE. `arm` during PRE → ignored.
- Re-arm from DONE: after scenario 2, arm → fill=0, triggered=0, busy=1, and rd_idx 0 reads 0 before the first new sample.
